pipe_ctrl: RTL and testbench

- Central pipeline control unit. It is the producer of the per-register control codes that every pipeline register (pc generator, IF/ID, ID/EX, EX/MEM, MEM/WB) consumes on its ctrl_signal input.
- It arbitrates stall requests from the IF, ID, EX and MEM stages, a branch redirect from EX, and an exception redirect from MEM.
- It emits stall, bubble and flush codes, plus a registered PC-redirect command for the pc generator.
- It also keeps a pending-redirect state machine and a stall watchdog.

---
 rtl/pipe_ctrl_pkg.sv | 38 +++
 rtl/pipe_ctrl_if.sv | 50 +++++
 rtl/pipe_ctrl_stall_watchdog.sv | 30 +++
 rtl/pipe_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl shared types: control codes, FSM states,
// and the per-register control bundle.
package pipe_ctrl_pkg;

  localparam int ADDR_BUS_W = 64;
  localparam int CTRL_BUS_W = 2;

  typedef enum logic [1:0] {
    CTRL_NORMAL  = 2'b00,
    CTRL_STALLED = 2'b01,
    CTRL_FLUSH   = 2'b10
  } ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PEND  = 2'b01,
    ST_ISSUE = 2'b10
  } state_e;

  typedef struct packed {
    ctrl_e pc;
    ctrl_e if_id;
    ctrl_e id_ex;
    ctrl_e ex_mem;
    ctrl_e mem_wb;
  } ctrl_t;

  function automatic ctrl_t ctrl_all(ctrl_e v);
    ctrl_t c;
    c.pc     = v;
    c.if_id  = v;
    c.id_ex  = v;
    c.ex_mem = v;
    c.mem_wb = v;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl request/control bundle.
// slave = control unit, master = pipeline side.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS_W,
  parameter int CTRL_W = CTRL_BUS_W
);
  logic              if_stall_req_i;
  logic              id_stall_req_i;
  logic              ex_stall_req_i;
  logic              mem_stall_req_i;
  logic              ex_redirect_i;
  logic [ADDR_W-1:0] ex_target_i;
  logic              exc_i;
  logic [ADDR_W-1:0] exc_vector_i;
  logic [CTRL_W-1:0] pc_ctrl_o;
  logic [CTRL_W-1:0] if_id_ctrl_o;
  logic [CTRL_W-1:0] id_ex_ctrl_o;
  logic [CTRL_W-1:0] ex_mem_ctrl_o;
  logic [CTRL_W-1:0] mem_wb_ctrl_o;
  logic              redirect_valid_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic [31:0]       stall_cycles_o;
  logic              stall_timeout_o;

  modport slave (
    input  if_stall_req_i, id_stall_req_i,
    input  ex_stall_req_i, mem_stall_req_i,
    input  ex_redirect_i, ex_target_i,
    input  exc_i, exc_vector_i,
    output pc_ctrl_o, if_id_ctrl_o,
    output id_ex_ctrl_o, ex_mem_ctrl_o,
    output mem_wb_ctrl_o,
    output redirect_valid_o, redirect_pc_o,
    output stall_cycles_o, stall_timeout_o
  );

  modport master (
    output if_stall_req_i, id_stall_req_i,
    output ex_stall_req_i, mem_stall_req_i,
    output ex_redirect_i, ex_target_i,
    output exc_i, exc_vector_i,
    input  pc_ctrl_o, if_id_ctrl_o,
    input  id_ex_ctrl_o, ex_mem_ctrl_o,
    input  mem_wb_ctrl_o,
    input  redirect_valid_o, redirect_pc_o,
    input  stall_cycles_o, stall_timeout_o
  );
endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Consecutive-stall watchdog: one-cycle timeout
// pulse every STALL_MAX back-to-back stalled cycles.
module stall_watchdog #(
  parameter int STALL_MAX = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_any,
  output logic timeout
);
  localparam int CW = $clog2(STALL_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(STALL_MAX - 1);

  logic [CW-1:0] cnt_q;
  logic          hit;

  assign hit = stall_any && (cnt_q == LAST);

  // count run length; restart on a gap or on expiry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= hit;
      if (!stall_any || hit) cnt_q <= '0;
      else cnt_q <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall/flush arbitration,
// pending-redirect FSM and stall statistics.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_BUS_W,
  parameter int CTRL_W    = CTRL_BUS_W,
  parameter int STALL_MAX = 1024
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              valid_q;
  logic [31:0]       scnt_q;
  logic              any_stall;
  logic              br_acc;
  logic              accept;
  logic              timeout;
  ctrl_t             c;

  assign any_stall = bus.if_stall_req_i
                   | bus.id_stall_req_i
                   | bus.ex_stall_req_i
                   | bus.mem_stall_req_i;

  // a branch is dropped under an exception and held
  // off while MEM stalls (EX keeps asserting it)
  assign br_acc = bus.ex_redirect_i
                & ~bus.exc_i
                & ~bus.mem_stall_req_i
                & (state_q == ST_IDLE);
  assign accept = bus.exc_i | br_acc;

  // redirect FSM next state and target latch
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    if (accept)
      tgt_d = bus.exc_i ? bus.exc_vector_i
                        : bus.ex_target_i;
    unique case (state_q)
      ST_IDLE, ST_ISSUE: begin
        if (accept)
          state_d = bus.if_stall_req_i ? ST_PEND
                                       : ST_ISSUE;
        else
          state_d = ST_IDLE;
      end
      ST_PEND: begin
        if (!bus.if_stall_req_i) state_d = ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, target and redirect strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      valid_q <= (state_d == ST_ISSUE);
    end
  end

  // control codes: exception, branch, then stalls
  always_comb begin
    c = ctrl_all(CTRL_NORMAL);
    if (bus.exc_i) begin
      c          = ctrl_all(CTRL_FLUSH);
      c.pc       = CTRL_STALLED;
      c.mem_wb   = CTRL_NORMAL;
    end else begin
      if (br_acc) begin
        c.pc     = CTRL_STALLED;
        c.if_id  = CTRL_FLUSH;
        c.id_ex  = CTRL_FLUSH;
      end else if (bus.mem_stall_req_i) begin
        c        = ctrl_all(CTRL_STALLED);
        c.mem_wb = CTRL_FLUSH;
      end else if (bus.ex_stall_req_i) begin
        c.pc     = CTRL_STALLED;
        c.if_id  = CTRL_STALLED;
        c.id_ex  = CTRL_STALLED;
        c.ex_mem = CTRL_FLUSH;
      end else if (bus.id_stall_req_i) begin
        c.pc     = CTRL_STALLED;
        c.if_id  = CTRL_STALLED;
        c.id_ex  = CTRL_FLUSH;
      end else if (bus.if_stall_req_i) begin
        c.pc     = CTRL_STALLED;
        c.if_id  = CTRL_FLUSH;
      end
      if (state_q == ST_PEND) begin
        c.pc     = CTRL_STALLED;
        c.if_id  = CTRL_FLUSH;
      end else if (state_q == ST_ISSUE) begin
        c.pc     = CTRL_NORMAL;
        c.if_id  = CTRL_FLUSH;
      end
    end
    if (!rst) c = ctrl_all(CTRL_NORMAL);
  end

  // saturating count of pc-stalled cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) scnt_q <= '0;
    else if (c.pc == CTRL_STALLED && scnt_q != '1)
      scnt_q <= scnt_q + 32'd1;
  end

  stall_watchdog #(
    .STALL_MAX (STALL_MAX)
  ) u_wd (
    .clk       (clk),
    .rst       (rst),
    .stall_any (any_stall),
    .timeout   (timeout)
  );

  assign bus.pc_ctrl_o        = CTRL_W'(c.pc);
  assign bus.if_id_ctrl_o     = CTRL_W'(c.if_id);
  assign bus.id_ex_ctrl_o     = CTRL_W'(c.id_ex);
  assign bus.ex_mem_ctrl_o    = CTRL_W'(c.ex_mem);
  assign bus.mem_wb_ctrl_o    = CTRL_W'(c.mem_wb);
  assign bus.redirect_valid_o = valid_q;
  assign bus.redirect_pc_o    = tgt_q;
  assign bus.stall_cycles_o   = scnt_q;
  assign bus.stall_timeout_o  = timeout;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl.
// Codes shown as {pc,if_id,id_ex,ex_mem,mem_wb}.
module tb_pipe_ctrl;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  pipe_ctrl_if #(.ADDR_W(64), .CTRL_W(2)) bus ();

  pipe_ctrl #(
    .ADDR_W    (64),
    .CTRL_W    (2),
    .STALL_MAX (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [9:0] codes;
  assign codes = {bus.pc_ctrl_o, bus.if_id_ctrl_o,
                  bus.id_ex_ctrl_o, bus.ex_mem_ctrl_o,
                  bus.mem_wb_ctrl_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_in();
    bus.if_stall_req_i  = 1'b0;
    bus.id_stall_req_i  = 1'b0;
    bus.ex_stall_req_i  = 1'b0;
    bus.mem_stall_req_i = 1'b0;
    bus.ex_redirect_i   = 1'b0;
    bus.ex_target_i     = '0;
    bus.exc_i           = 1'b0;
    bus.exc_vector_i    = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.ex_redirect_i = 1'b1;
    bus.ex_target_i   = 64'hABC;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (codes !== 10'b00_00_00_00_00) begin
      n_fail++;
      $display("FAIL reset_codes got %b exp %b",
               codes, 10'b0);
    end
    n_chk++;
    if (bus.redirect_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b exp 0",
               bus.redirect_valid_o);
    end
    n_chk++;
    if (bus.redirect_pc_o !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_pc got %h exp 0",
               bus.redirect_pc_o);
    end
    n_chk++;
    if (bus.stall_cycles_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_scnt got %0d exp 0",
               bus.stall_cycles_o);
    end
    n_chk++;
    if (bus.stall_timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tmo got %b exp 0",
               bus.stall_timeout_o);
    end
    clear_in();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.redirect_valid_o !== 1'b0 ||
        codes !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_discard valid %b codes %b exp 0",
               bus.redirect_valid_o, codes);
    end
  endtask

  task automatic test_stall_priority();
    @(negedge clk);
    bus.ex_stall_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (codes !== 10'b01_01_01_10_00) begin
        n_fail++;
        $display("FAIL ex_stall[%0d] got %b exp %b",
                 i, codes, 10'b01_01_01_10_00);
      end
      @(negedge clk);
    end
    #1;
    n_chk++;
    if (bus.stall_cycles_o !== 32'd3) begin
      n_fail++;
      $display("FAIL stall_cycles got %0d exp 3",
               bus.stall_cycles_o);
    end
    bus.mem_stall_req_i = 1'b1;
    #1;
    n_chk++;
    if (codes !== 10'b01_01_01_01_10) begin
      n_fail++;
      $display("FAIL mem_over_ex got %b exp %b",
               codes, 10'b01_01_01_01_10);
    end
    bus.ex_stall_req_i  = 1'b0;
    bus.mem_stall_req_i = 1'b0;
    bus.id_stall_req_i  = 1'b1;
    bus.if_stall_req_i  = 1'b1;
    #1;
    n_chk++;
    if (codes !== 10'b01_01_10_00_00) begin
      n_fail++;
      $display("FAIL id_stall got %b exp %b",
               codes, 10'b01_01_10_00_00);
    end
    bus.id_stall_req_i = 1'b0;
    #1;
    n_chk++;
    if (codes !== 10'b01_10_00_00_00) begin
      n_fail++;
      $display("FAIL if_stall got %b exp %b",
               codes, 10'b01_10_00_00_00);
    end
    clear_in();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_ex_redirect();
    @(negedge clk);
    bus.ex_redirect_i = 1'b1;
    bus.ex_target_i   = 64'h8000_0040;
    #1;
    n_chk++;
    if (codes !== 10'b01_10_10_00_00) begin
      n_fail++;
      $display("FAIL br_codes got %b exp %b",
               codes, 10'b01_10_10_00_00);
    end
    n_chk++;
    if (bus.redirect_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL br_early_valid got %b exp 0",
               bus.redirect_valid_o);
    end
    @(negedge clk);
    clear_in();
    #1;
    n_chk++;
    if (bus.redirect_valid_o !== 1'b1 ||
        bus.redirect_pc_o !== 64'h8000_0040) begin
      n_fail++;
      $display("FAIL br_issue valid %b pc %h exp 1 %h",
               bus.redirect_valid_o, bus.redirect_pc_o,
               64'h8000_0040);
    end
    n_chk++;
    if (codes !== 10'b00_10_00_00_00) begin
      n_fail++;
      $display("FAIL br_issue_codes got %b exp %b",
               codes, 10'b00_10_00_00_00);
    end
    @(negedge clk);
    n_chk++;
    if (bus.redirect_valid_o !== 1'b0 ||
        codes !== 10'b0) begin
      n_fail++;
      $display("FAIL br_done valid %b codes %b exp 0",
               bus.redirect_valid_o, codes);
    end
  endtask

  task automatic test_pending();
    @(negedge clk);
    bus.exc_i          = 1'b1;
    bus.exc_vector_i   = 64'h100;
    bus.if_stall_req_i = 1'b1;
    #1;
    n_chk++;
    if (codes !== 10'b01_10_10_10_00) begin
      n_fail++;
      $display("FAIL exc_codes got %b exp %b",
               codes, 10'b01_10_10_10_00);
    end
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      bus.exc_i = 1'b0;
      if (i == 4) bus.if_stall_req_i = 1'b0;
      #1;
      n_chk++;
      if (bus.pc_ctrl_o !== 2'b01 ||
          bus.if_id_ctrl_o !== 2'b10 ||
          bus.redirect_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL pend[%0d] pc %b ifid %b v %b exp 01 10 0",
                 i, bus.pc_ctrl_o, bus.if_id_ctrl_o,
                 bus.redirect_valid_o);
      end
    end
    @(negedge clk);
    n_chk++;
    if (bus.redirect_valid_o !== 1'b1 ||
        bus.redirect_pc_o !== 64'h100 ||
        bus.pc_ctrl_o !== 2'b00) begin
      n_fail++;
      $display("FAIL pend_issue v %b pc %h pcc %b exp 1 100 00",
               bus.redirect_valid_o, bus.redirect_pc_o,
               bus.pc_ctrl_o);
    end
    @(negedge clk);
    n_chk++;
    if (bus.redirect_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_done v %b exp 0",
               bus.redirect_valid_o);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    bus.exc_i         = 1'b1;
    bus.exc_vector_i  = 64'h100;
    bus.ex_redirect_i = 1'b1;
    bus.ex_target_i   = 64'h200;
    #1;
    n_chk++;
    if (codes !== 10'b01_10_10_10_00) begin
      n_fail++;
      $display("FAIL simul_codes got %b exp %b",
               codes, 10'b01_10_10_10_00);
    end
    @(negedge clk);
    clear_in();
    #1;
    n_chk++;
    if (bus.redirect_valid_o !== 1'b1 ||
        bus.redirect_pc_o !== 64'h100) begin
      n_fail++;
      $display("FAIL simul_issue v %b pc %h exp 1 100",
               bus.redirect_valid_o, bus.redirect_pc_o);
    end
    @(negedge clk);
    n_chk++;
    if (bus.redirect_valid_o !== 1'b0 ||
        bus.redirect_pc_o !== 64'h100) begin
      n_fail++;
      $display("FAIL simul_done v %b pc %h exp 0 100",
               bus.redirect_valid_o, bus.redirect_pc_o);
    end
  endtask

  task automatic test_watchdog();
    logic exp;
    @(negedge clk);
    bus.id_stall_req_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      exp = (i == 8 || i == 16);
      n_chk++;
      if (bus.stall_timeout_o !== exp) begin
        n_fail++;
        $display("FAIL wd_run[%0d] got %b exp %b",
                 i, bus.stall_timeout_o, exp);
      end
    end
    bus.id_stall_req_i = 1'b0;
    @(negedge clk);
    bus.id_stall_req_i = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      exp = (j == 8);
      n_chk++;
      if (bus.stall_timeout_o !== exp) begin
        n_fail++;
        $display("FAIL wd_gap[%0d] got %b exp %b",
                 j, bus.stall_timeout_o, exp);
      end
    end
    clear_in();
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    clear_in();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_stall_priority();
    test_ex_redirect();
    test_pending();
    test_simultaneous();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
